// File: rtl/mgmt_storage_selftest_pkg.sv
// Shared definitions for the management storage self-test: status codes,
// FSM state encoding and the address-derived test pattern.
package mgmt_storage_pkg;

  localparam logic [15:0] CODE_B0_START = 16'hA040;
  localparam logic [15:0] CODE_B0_FAIL  = 16'hAB40;
  localparam logic [15:0] CODE_B0_PASS  = 16'hAB41;
  localparam logic [15:0] CODE_B1_START = 16'hA020;
  localparam logic [15:0] CODE_B1_FAIL  = 16'hAB20;
  localparam logic [15:0] CODE_B1_PASS  = 16'hAB21;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_S0   = 4'd1,
    ST_W0   = 4'd2,
    ST_R0   = 4'd3,
    ST_F0   = 4'd4,
    ST_P0   = 4'd5,
    ST_S1   = 4'd6,
    ST_W1   = 4'd7,
    ST_R1   = 4'd8,
    ST_F1   = 4'd9,
    ST_P1   = 4'd10
  } state_e;

  // Upper half is the complement of the lower half so every bit is exercised.
  function automatic logic [31:0] pattern(input logic [15:0] a16);
    return {~a16, a16};
  endfunction

endpackage

// File: rtl/mgmt_storage_selftest_bank.sv
// Single-port synchronous storage bank: one write or read per cycle,
// registered read data with one cycle of latency. Contents are not reset.
module storage_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

  // Array write and registered read port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mgmt_storage_selftest.sv
// Top level: two storage banks plus the write/read-back self-test sequencer
// that reports progress and verdict as 16-bit status codes.
module mgmt_storage_selftest
  import mgmt_storage_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int HOLD   = 4
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              inj_en,
  input  logic              inj_blk,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic [15:0]       checkbits,
  output logic              done,
  output logic              pass
);

  localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cmp_addr_q, cmp_addr_d;
  logic              cmp_vld_q, cmp_vld_d, last_q, last_d;
  logic              done_q, done_d, pass_q, pass_d;
  logic [15:0]       code_q, code_d;
  logic              we0, we1, in_b1, inj_hit, mismatch;
  logic [DATA_W-1:0] wdata, rdata0, rdata1, rdata_chk;

  storage_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_block0 (
    .clock(clock), .we(we0), .addr(addr_q), .wdata(wdata), .rdata(rdata0)
  );

  storage_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_block1 (
    .clock(clock), .we(we1), .addr(addr_q), .wdata(wdata), .rdata(rdata1)
  );

  // Injection is applied to the word being compared, so it is sampled live.
  assign in_b1     = (state_q == ST_R1);
  assign wdata     = DATA_W'(pattern(16'(addr_q)));
  assign inj_hit   = inj_en && (inj_blk == in_b1) && (cmp_addr_q == inj_addr);
  assign rdata_chk = (in_b1 ? rdata1 : rdata0) ^ {{(DATA_W-1){1'b0}}, inj_hit};
  assign mismatch  = cmp_vld_q && (rdata_chk != DATA_W'(pattern(16'(cmp_addr_q))));

  // Sequencer next-state and status-code logic.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    cmp_addr_d = cmp_addr_q;
    cmp_vld_d  = 1'b0;
    last_d     = last_q;
    code_d     = code_q;
    done_d     = done_q;
    pass_d     = pass_q;
    we0        = 1'b0;
    we1        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_S0;
        code_d  = CODE_B0_START;
        hold_d  = '0;
      end
      ST_S0, ST_S1: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (state_q == ST_S0) ? ST_W0 : ST_W1;
          addr_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_W0, ST_W1: begin
        we0 = (state_q == ST_W0);
        we1 = (state_q == ST_W1);
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == ST_W0) ? ST_R0 : ST_R1;
          addr_d  = '0;
          last_d  = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_R0, ST_R1: begin
        // last_q means every read is issued and the final word is in compare.
        if (mismatch) begin
          state_d = in_b1 ? ST_F1 : ST_F0;
          code_d  = in_b1 ? CODE_B1_FAIL : CODE_B0_FAIL;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else if (last_q) begin
          if (in_b1) begin
            state_d = ST_P1;
            code_d  = CODE_B1_PASS;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_P0;
            code_d  = CODE_B0_PASS;
            hold_d  = '0;
          end
        end else begin
          cmp_vld_d  = 1'b1;
          cmp_addr_d = addr_q;
          if (addr_q == LAST_ADDR) begin
            last_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_P0: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_S1;
          code_d  = CODE_B1_START;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_F0, ST_F1, ST_P1: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      addr_q     <= '0;
      cmp_addr_q <= '0;
      cmp_vld_q  <= 1'b0;
      last_q     <= 1'b0;
      code_q     <= 16'h0000;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      last_q     <= last_d;
      code_q     <= code_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign checkbits = code_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_mgmt_storage_selftest.sv
// Self-checking bench for mgmt_storage_selftest: code timelines are predicted
// from the phase durations and compared against the observed checkbits changes.
module tb_mgmt_storage_selftest;

  localparam int D  = 256;
  localparam int H  = 4;
  localparam int SD = 4;
  localparam int SH = 1;
  localparam int BUDGET = 1300;

  localparam logic [15:0] K_B0_START = 16'hA040;
  localparam logic [15:0] K_B0_FAIL  = 16'hAB40;
  localparam logic [15:0] K_B0_PASS  = 16'hAB41;
  localparam logic [15:0] K_B1_START = 16'hA020;
  localparam logic [15:0] K_B1_FAIL  = 16'hAB20;
  localparam logic [15:0] K_B1_PASS  = 16'hAB21;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        inj_en = 1'b0;
  logic        inj_blk = 1'b0;
  logic [7:0]  inj_addr = 8'd0;
  logic [15:0] checkbits;
  logic        done, pass;

  logic        s_resetb = 1'b0;
  logic        s_inj_en = 1'b0;
  logic        s_inj_blk = 1'b0;
  logic [1:0]  s_inj_addr = 2'd0;
  logic [15:0] s_checkbits;
  logic        s_done, s_pass;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ev_cyc[$];
  logic [15:0] ev_code[$];
  int          exp_cyc[$];
  logic [15:0] exp_code[$];
  bit          exp_pass;
  int          done_cyc;
  bit          timed_out;

  always #5 clock = ~clock;

  mgmt_storage_selftest #(.ADDR_W(8), .DATA_W(32), .HOLD(H)) dut (
    .clock(clock), .resetb(resetb), .inj_en(inj_en), .inj_blk(inj_blk),
    .inj_addr(inj_addr), .checkbits(checkbits), .done(done), .pass(pass)
  );

  mgmt_storage_selftest #(.ADDR_W(2), .DATA_W(32), .HOLD(SH)) dut_small (
    .clock(clock), .resetb(s_resetb), .inj_en(s_inj_en), .inj_blk(s_inj_blk),
    .inj_addr(s_inj_addr), .checkbits(s_checkbits), .done(s_done), .pass(s_pass)
  );

  // Expected (edge-after-release, code) timeline from the phase lengths:
  // IDLE 1, start HOLD, write DEPTH, read DEPTH+1, pass-hold HOLD; a failing
  // word a is flagged two edges after its read phase begins plus a.
  task automatic build_expected(input bit inj, input bit blk, input int a,
                                input int d, input int h);
    int r0, r1;
    exp_cyc.delete();
    exp_code.delete();
    r0 = 1 + h + d;
    exp_cyc.push_back(1); exp_code.push_back(K_B0_START);
    if (inj && !blk) begin
      exp_cyc.push_back(r0 + a + 2); exp_code.push_back(K_B0_FAIL);
      exp_pass = 1'b0;
    end else begin
      exp_cyc.push_back(r0 + d + 1);     exp_code.push_back(K_B0_PASS);
      exp_cyc.push_back(r0 + d + 1 + h); exp_code.push_back(K_B1_START);
      r1 = r0 + d + 1 + 2 * h + d;
      if (inj && blk) begin
        exp_cyc.push_back(r1 + a + 2); exp_code.push_back(K_B1_FAIL);
        exp_pass = 1'b0;
      end else begin
        exp_cyc.push_back(r1 + d + 1); exp_code.push_back(K_B1_PASS);
        exp_pass = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    resetb = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  // Release reset and log every checkbits change until done or budget.
  task automatic run_main();
    logic [15:0] prev;
    ev_cyc.delete();
    ev_code.delete();
    @(negedge clock);
    resetb = 1'b1;
    prev = checkbits;
    done_cyc = -1;
    timed_out = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clock);
      #1;
      if (checkbits !== prev) begin
        ev_cyc.push_back(c);
        ev_code.push_back(checkbits);
        prev = checkbits;
      end
      if (done === 1'b1) begin
        done_cyc = c;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (checkbits !== 16'h0000 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got cb=%h done=%b pass=%b, need 0000/0/0", checkbits, done, pass);
    end
  endtask

  task automatic test_nominal();
    int n;
    inj_en = 1'b0;
    inj_blk = 1'b1;
    inj_addr = 8'($urandom_range(0, D - 1));
    build_expected(1'b0, 1'b0, 0, D, H);
    apply_reset();
    run_main();
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL nominal_timeout: done not seen in %0d cycles", BUDGET); end
    n_checks++;
    if (ev_cyc.size() != exp_cyc.size()) begin
      n_fail++; $display("FAIL nominal_events: got %0d code changes, need %0d", ev_cyc.size(), exp_cyc.size());
    end
    n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (ev_code[i] !== exp_code[i] || ev_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL nominal_ev%0d: got %h@%0d, need %h@%0d", i, ev_code[i], ev_cyc[i], exp_code[i], exp_cyc[i]);
      end
    end
    n_checks++;
    if (done_cyc != exp_cyc[exp_cyc.size()-1] || pass !== exp_pass) begin
      n_fail++; $display("FAIL nominal_done: got cyc=%0d pass=%b, need cyc=%0d pass=%b", done_cyc, pass, exp_cyc[exp_cyc.size()-1], exp_pass);
    end
    repeat (20) @(posedge clock);
    #1;
    n_checks++;
    if (checkbits !== K_B1_PASS || done !== 1'b1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL nominal_terminal_hold: got cb=%h done=%b pass=%b, need %h/1/1", checkbits, done, pass, K_B1_PASS);
    end
  endtask

  // Fixed corner cases first (block0 word 5, block1 last word, block0 word 0),
  // then randomly chosen bank/address pairs.
  task automatic test_injection();
    int n, a;
    bit blk;
    for (int t = 0; t < 7; t++) begin
      case (t)
        0: begin blk = 1'b0; a = 5; end
        1: begin blk = 1'b1; a = D - 1; end
        2: begin blk = 1'b0; a = 0; end
        default: begin blk = 1'($urandom_range(0, 1)); a = $urandom_range(0, D - 1); end
      endcase
      inj_en = 1'b1;
      inj_blk = blk;
      inj_addr = 8'(a);
      build_expected(1'b1, blk, a, D, H);
      apply_reset();
      run_main();
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL inj%0d_timeout: blk=%0d addr=%0d", t, blk, a); end
      n_checks++;
      if (ev_cyc.size() != exp_cyc.size()) begin
        n_fail++; $display("FAIL inj%0d_events: got %0d code changes, need %0d", t, ev_cyc.size(), exp_cyc.size());
      end
      n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (ev_code[i] !== exp_code[i] || ev_cyc[i] != exp_cyc[i]) begin
          n_fail++;
          $display("FAIL inj%0d_ev%0d: got %h@%0d, need %h@%0d (blk=%0d addr=%0d)", t, i, ev_code[i], ev_cyc[i], exp_code[i], exp_cyc[i], blk, a);
        end
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
        n_fail++; $display("FAIL inj%0d_verdict: got done=%b pass=%b, need 1/0", t, done, pass);
      end
      if (t == 2) begin
        n_checks++;
        if (ev_cyc.size() > 1 && ev_cyc[1] != 1 + H + D + 2) begin
          n_fail++; $display("FAIL inj_first_word_latency: got AB40 at %0d, need %0d", ev_cyc[1], 1 + H + D + 2);
        end
      end
    end
    inj_en = 1'b0;
  endtask

  task automatic test_reset_mid_w1();
    int n;
    bit seen;
    inj_en = 1'b0;
    apply_reset();
    @(negedge clock);
    resetb = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(posedge clock);
      #1;
      if (checkbits === K_B1_START) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midw1_reach: A020 not seen, cb=%h", checkbits); end
    repeat (H + 20) @(posedge clock);
    #2;
    resetb = 1'b0;
    #1;
    n_checks++;
    if (checkbits !== 16'h0000 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL midw1_async_clear: got cb=%h done=%b pass=%b, need 0000/0/0", checkbits, done, pass);
    end
    build_expected(1'b0, 1'b0, 0, D, H);
    run_main();
    n_checks++;
    if (timed_out || ev_cyc.size() != exp_cyc.size()) begin
      n_fail++; $display("FAIL midw1_rerun: got %0d code changes timeout=%0d, need %0d", ev_cyc.size(), timed_out, exp_cyc.size());
    end
    n = (ev_cyc.size() < exp_cyc.size()) ? ev_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (ev_code[i] !== exp_code[i] || ev_cyc[i] != exp_cyc[i]) begin
        n_fail++;
        $display("FAIL midw1_ev%0d: got %h@%0d, need %h@%0d", i, ev_code[i], ev_cyc[i], exp_code[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_small_config();
    int          n, dc;
    int          sc[$];
    logic [15:0] sk[$];
    logic [15:0] prev;
    build_expected(1'b0, 1'b0, 0, SD, SH);
    s_resetb = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    s_resetb = 1'b1;
    prev = s_checkbits;
    dc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      #1;
      if (s_checkbits !== prev) begin sc.push_back(c); sk.push_back(s_checkbits); prev = s_checkbits; end
      if (s_done === 1'b1) begin dc = c; break; end
    end
    n_checks++;
    if (sc.size() != exp_cyc.size()) begin
      n_fail++; $display("FAIL small_events: got %0d code changes, need %0d", sc.size(), exp_cyc.size());
    end
    n = (sc.size() < exp_cyc.size()) ? sc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (sk[i] !== exp_code[i] || sc[i] != exp_cyc[i]) begin
        n_fail++; $display("FAIL small_ev%0d: got %h@%0d, need %h@%0d", i, sk[i], sc[i], exp_code[i], exp_cyc[i]);
      end
    end
    n_checks++;
    if (dc != exp_cyc[exp_cyc.size()-1] || s_pass !== 1'b1) begin
      n_fail++; $display("FAIL small_done: got cyc=%0d pass=%b, need cyc=%0d pass=1", dc, s_pass, exp_cyc[exp_cyc.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_injection();
    test_reset_mid_w1();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
